// File: rtl/aligner_pkg.sv
// Shared constants and types for the operand aligner slice.
// DATA_WIDTH (optional macro) overrides the default operand width.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package aligner_pkg;

  localparam int unsigned DATA_W_DEF = `DATA_WIDTH;

  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned DROP_CNT_W = 16;

  typedef logic [$clog2(DEPTH_DEF)-1:0] ptr_t;
  typedef logic [$clog2(DEPTH_DEF):0]   cnt_t;

  // Saturating increment for the drop counters.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO used per operand stream. The pop request comes from the
// consumer; a write while full is only accepted if a pop frees a slot the
// same cycle, otherwise it is reported through drop.
module sync_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              drop
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W:0]    count;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept;

    // Status from the registered count; write acceptance and drop decision.
    always_comb begin
        full   = (count == (PTR_W+1)'(DEPTH));
        empty  = (count == '0);
        accept = !rst && wr_en && (!full || pop);
        drop   = !rst && wr_en && full && !pop;
        dout   = mem[rptr];
    end

    // Storage write; data needs no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wptr] <= din;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (accept)
                wptr <= wptr + PTR_W'(1);
            if (pop)
                rptr <= rptr + PTR_W'(1);
            case ({accept, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/operand_aligner.sv
// Aligns two independent operand streams into registered pairs for the adder.
// Optional macro ALIGNER_DROP_CNT_EN adds per-stream saturating drop counters.
module operand_aligner
    import aligner_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] dinp_a,
    input  logic              valid_a,
    input  logic [DATA_W-1:0] dinp_b,
    input  logic              valid_b,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              valid_out,
    output logic              full_a,
    output logic              full_b,
    output logic              ovf_a,
    output logic              ovf_b
`ifdef ALIGNER_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt_a,
    output logic [DROP_CNT_W-1:0] drop_cnt_b
`endif
);
    logic [DATA_W-1:0] dout_a;
    logic [DATA_W-1:0] dout_b;
    logic              empty_a;
    logic              empty_b;
    logic              drop_a;
    logic              drop_b;
    logic              pop;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .wr_en (valid_a),
        .din   (dinp_a),
        .pop   (pop),
        .dout  (dout_a),
        .empty (empty_a),
        .full  (full_a),
        .drop  (drop_a)
    );

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .wr_en (valid_b),
        .din   (dinp_b),
        .pop   (pop),
        .dout  (dout_b),
        .empty (empty_b),
        .full  (full_b),
        .drop  (drop_b)
    );

    // A pair is released whenever both FIFOs hold at least one word.
    always_comb begin
        pop = !rst && !empty_a && !empty_b;
    end

    // Output pair registers and sticky overflow flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            ovf_a     <= 1'b0;
            ovf_b     <= 1'b0;
        end else begin
            valid_out <= pop;
            if (pop) begin
                out_a <= dout_a;
                out_b <= dout_b;
            end
            if (drop_a)
                ovf_a <= 1'b1;
            if (drop_b)
                ovf_b <= 1'b1;
        end
    end

`ifdef ALIGNER_DROP_CNT_EN
    // Saturating per-stream counts of discarded words.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_a <= '0;
            drop_cnt_b <= '0;
        end else begin
            if (drop_a)
                drop_cnt_a <= sat_inc(drop_cnt_a);
            if (drop_b)
                drop_cnt_b <= sat_inc(drop_cnt_b);
        end
    end
`endif

endmodule

// File: tb/tb_operand_aligner.sv
// Directed, table-driven bench for operand_aligner (DEPTH=8, DATA_W=16).
module tb_operand_aligner;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dinp_a;
    logic        valid_a;
    logic [15:0] dinp_b;
    logic        valid_b;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic        valid_out;
    logic        full_a;
    logic        full_b;
    logic        ovf_a;
    logic        ovf_b;
`ifdef ALIGNER_DROP_CNT_EN
    logic [15:0] drop_cnt_a;
    logic [15:0] drop_cnt_b;
`endif

    always #5 clk = ~clk;

    operand_aligner #(.DATA_W(16), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .dinp_a    (dinp_a),
        .valid_a   (valid_a),
        .dinp_b    (dinp_b),
        .valid_b   (valid_b),
        .out_a     (out_a),
        .out_b     (out_b),
        .valid_out (valid_out),
        .full_a    (full_a),
        .full_b    (full_b),
        .ovf_a     (ovf_a),
        .ovf_b     (ovf_b)
`ifdef ALIGNER_DROP_CNT_EN
        ,
        .drop_cnt_a (drop_cnt_a),
        .drop_cnt_b (drop_cnt_b)
`endif
    );

    typedef struct {
        logic        r;
        logic        va;
        logic [15:0] da;
        logic        vb;
        logic [15:0] db;
        logic        evo;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        efa;
        logic        efb;
        logic        eoa;
        logic        eob;
        logic [15:0] edca;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    logic [15:0] rnd_a[100];
    logic [15:0] rnd_b[100];

    // Each entry: inputs driven for one cycle, expected outputs after that edge.
    function automatic void add(input logic r, input logic va, input int da,
                                input logic vb, input int db,
                                input logic evo, input int ea, input int eb,
                                input logic efa, input logic efb,
                                input logic eoa, input logic eob, input int edca);
        vec_t v;
        v.r = r;  v.va = va; v.da = 16'(da); v.vb = vb; v.db = 16'(db);
        v.evo = evo; v.ea = 16'(ea); v.eb = 16'(eb);
        v.efa = efa; v.efb = efb; v.eoa = eoa; v.eob = eob; v.edca = 16'(edca);
        vecs.push_back(v);
    endfunction

    function automatic void fill_table();
        // reset
        add(1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
        // single pair, 2-cycle latency, one-cycle strobe, outputs hold
        add(0, 1, 3, 1, 5,  0, 0, 0,  0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,  1, 3, 5,  0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,  0, 3, 5,  0, 0, 0, 0, 0);
        // skew: A leads B by 6 cycles
        for (int i = 0; i < 4; i++) add(0, 1, 1 + i, 0, 0,  0, 3, 5,  0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,  0, 3, 5,  0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,  0, 3, 5,  0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 10, 0, 3, 5,  0, 0, 0, 0, 0);
        for (int i = 1; i < 4; i++) add(0, 0, 0, 1, 10 + i,  1, i, 9 + i,  0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,  1, 4, 13, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,  0, 4, 13, 0, 0, 0, 0, 0);
        // overflow: A writes 0..8, word 8 dropped
        for (int i = 0; i < 9; i++)
            add(0, 1, i, 0, 0,  0, 4, 13,  i >= 7, 0, i == 8, 0, (i == 8) ? 1 : 0);
        add(0, 0, 0, 1, 100,  0, 4, 13,  1, 0, 1, 0, 1);
        for (int i = 1; i < 8; i++) add(0, 0, 0, 1, 100 + i,  1, i - 1, 99 + i,  0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0,  1, 7, 107,  0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0,  0, 7, 107,  0, 0, 1, 0, 1);
        add(1, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0, 0, 0);
        // full A plus write in the pop cycle: accepted, no overflow
        for (int i = 0; i < 8; i++) add(0, 1, 20 + i, 0, 0,  0, 0, 0,  i == 7, 0, 0, 0, 0);
        add(0, 0, 0, 1, 50,  0, 0, 0,    1, 0, 0, 0, 0);
        add(0, 1, 28, 0, 0,  1, 20, 50,  1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   0, 20, 50,  1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 51,  0, 20, 50,  1, 0, 0, 0, 0);
        for (int i = 1; i < 8; i++) add(0, 0, 0, 1, 51 + i,  1, 20 + i, 50 + i,  0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,  1, 28, 58,  0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,  0, 28, 58,  0, 0, 0, 0, 0);
        // reset mid-operation (write during reset must be ignored)
        for (int i = 0; i < 3; i++) add(0, 1, 70 + i, 0, 0,  0, 28, 58,  0, 0, 0, 0, 0);
        add(1, 1, 99, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 80 + i,  0, 0, 0,  0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0);
        add(0, 1, 90, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,  1, 90, 80, 0, 0, 0, 0, 0);
        add(0, 1, 91, 0, 0, 0, 90, 80, 0, 0, 0, 0, 0);
        add(0, 1, 92, 0, 0, 1, 91, 81, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,  1, 92, 82, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,  0, 92, 82, 0, 0, 0, 0, 0);
    endfunction

    initial begin
        rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; dinp_a = '0; dinp_b = '0;
        fill_table();
        for (int i = 0; i < 100; i++) begin
            rnd_a[i] = 16'($urandom);
            rnd_b[i] = 16'($urandom);
        end
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            logic ok;
            rst = vecs[i].r; valid_a = vecs[i].va; dinp_a = vecs[i].da;
            valid_b = vecs[i].vb; dinp_b = vecs[i].db;
            @(posedge clk); #1;
            n_vec++;
            ok = (valid_out === vecs[i].evo) && (out_a === vecs[i].ea) && (out_b === vecs[i].eb)
                 && (full_a === vecs[i].efa) && (full_b === vecs[i].efb)
                 && (ovf_a === vecs[i].eoa) && (ovf_b === vecs[i].eob);
`ifdef ALIGNER_DROP_CNT_EN
            ok = ok && (drop_cnt_a === vecs[i].edca) && (drop_cnt_b === 16'd0);
`endif
            if (!ok) begin
                n_fail++;
                $display("FAIL vec%0d: got vo=%b a=%0d b=%0d fa=%b fb=%b oa=%b ob=%b, want vo=%b a=%0d b=%0d fa=%b fb=%b oa=%b ob=%b dca=%0d",
                         i, valid_out, out_a, out_b, full_a, full_b, ovf_a, ovf_b,
                         vecs[i].evo, vecs[i].ea, vecs[i].eb, vecs[i].efa, vecs[i].efb,
                         vecs[i].eoa, vecs[i].eob, vecs[i].edca);
            end
        end

        // 100 back-to-back random pairs: continuous valid_out, order preserved, pointers wrap
        for (int k = 0; k < 102; k++) begin
            logic        evo;
            logic [15:0] ea;
            logic [15:0] eb;
            rst = 1'b0;
            valid_a = (k < 100); valid_b = (k < 100);
            dinp_a = (k < 100) ? rnd_a[k] : 16'd0;
            dinp_b = (k < 100) ? rnd_b[k] : 16'd0;
            @(posedge clk); #1;
            n_vec++;
            evo = (k >= 1) && (k <= 100);
            ea  = (k == 0) ? 16'd92 : rnd_a[(k >= 101) ? 99 : k - 1];
            eb  = (k == 0) ? 16'd82 : rnd_b[(k >= 101) ? 99 : k - 1];
            if (valid_out !== evo || out_a !== ea || out_b !== eb || full_a !== 1'b0
                || full_b !== 1'b0 || ovf_a !== 1'b0 || ovf_b !== 1'b0) begin
                n_fail++;
                $display("FAIL stream%0d: got vo=%b a=%h b=%h fa=%b fb=%b, want vo=%b a=%h b=%h fa=0 fb=0",
                         k, valid_out, out_a, out_b, full_a, full_b, evo, ea, eb);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
